// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit seven-segment scan controller.
package seg_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;

    typedef logic [SEL_W-1:0]      sel_t;
    typedef logic [NUM_DIGITS-1:0] an_t;

    // All anodes released (the anode lines are active-low).
    localparam an_t AN_OFF = 4'b1111;

    // Active-low one-hot anode pattern for the selected digit.
    function automatic an_t onehot_low(input sel_t sel);
        an_t one;
        one = an_t'(1);
        return ~(one << sel);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Control inputs and display outputs of the scan controller, grouped as one bundle.
interface seg_scan_ctrl_if;
    import seg_scan_ctrl_pkg::*;

    logic        en;
    an_t         digit_en;
    logic [2:0]  brightness;
    sel_t        choice;
    an_t         an;
    logic        frame_tick;

    // The master drives the controls and watches the display lines.
    modport master (
        output en, digit_en, brightness,
        input  choice, an, frame_tick
    );

    // The scan controller consumes the controls and drives the display lines.
    modport slave (
        input  en, digit_en, brightness,
        output choice, an, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl_refresh_counter.sv
// Per-slot cycle counter: counts while enabled, wraps at REFRESH_DIV-1, and
// exposes its next value so the parent can register outputs in step with it.
module refresh_counter #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nx,
    output logic             wrap
);

    // Next count: hold when disabled, return to zero at the end of a slot.
    always_comb begin
        wrap   = en && (cnt == CNT_W'(REFRESH_DIV - 1));
        cnt_nx = cnt;
        if (wrap)
            cnt_nx = '0;
        else if (en)
            cnt_nx = cnt + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= cnt_nx;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display with
// blanking dead-time, 8-level PWM brightness and a per-digit show mask.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic           clk,
    input  logic           reset,
    seg_scan_ctrl_if.slave bus
);

    localparam int SPAN8 = (REFRESH_DIV - BLANK_CYCLES) / 8;
    localparam int LIM_W = CNT_W + 3;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             wrap;

    sel_t       choice_q;
    sel_t       choice_nx;
    logic [2:0] bri_q;
    logic [2:0] bri_nx;
    an_t        mask_q;
    an_t        mask_nx;
    an_t        an_q;
    an_t        an_nx;
    logic       frame_tick_q;

    logic [LIM_W-1:0] on_limit;
    logic [LIM_W-1:0] cnt_ext;
    logic             in_window;

    refresh_counter #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .en     (bus.en),
        .cnt    (cnt),
        .cnt_nx (cnt_nx),
        .wrap   (wrap)
    );

    // Next-state digit/brightness/mask and the anode pattern that goes with it,
    // so the anode register always matches the choice register.
    always_comb begin
        choice_nx = wrap ? choice_q + sel_t'(1) : choice_q;
        bri_nx    = wrap ? bus.brightness : bri_q;
        mask_nx   = wrap ? bus.digit_en   : mask_q;

        if (bri_nx == 3'd7)
            on_limit = LIM_W'(REFRESH_DIV);
        else
            on_limit = LIM_W'(BLANK_CYCLES) + LIM_W'(SPAN8) * (LIM_W'(bri_nx) + LIM_W'(1));

        cnt_ext   = LIM_W'(cnt_nx);
        in_window = (cnt_ext >= LIM_W'(BLANK_CYCLES)) && (cnt_ext < on_limit);

        an_nx = AN_OFF;
        if (bus.en && mask_nx[choice_nx] && in_window)
            an_nx = onehot_low(choice_nx);
    end

    // Output and slot-sample registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            choice_q     <= '0;
            bri_q        <= 3'd7;
            mask_q       <= AN_OFF;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            choice_q     <= choice_nx;
            bri_q        <= bri_nx;
            mask_q       <= mask_nx;
            an_q         <= an_nx;
            frame_tick_q <= wrap && (choice_q == sel_t'(NUM_DIGITS - 1));
        end
    end

    assign bus.choice     = choice_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = frame_tick_q;

endmodule
